// File: rtl/draw_paddles.sv
// Two-paddle overlay stage: draws the left and right paddles over the incoming pixel stream.
// It adds two cycles of latency, latches paddle Y once per frame, and gives each paddle its own hit-flash FSM.
module draw_paddles #(
    parameter int WIDTH        = 10,
    parameter int LENGTH       = 80,
    parameter int XPOS_L       = 60,
    parameter int XPOS_R       = 963,
    parameter int V_ACTIVE     = 768,
    parameter int RGB_W        = 12,
    parameter int FLASH_FRAMES = 8
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic [10:0]      vcount_in,
    input  logic [10:0]      hcount_in,
    input  logic             vsync_in,
    input  logic             hsync_in,
    input  logic             vblnk_in,
    input  logic             hblnk_in,
    input  logic [RGB_W-1:0] rgb_in,
    input  logic [11:0]      y_pos_l,
    input  logic [11:0]      y_pos_r,
    input  logic [RGB_W-1:0] color_l,
    input  logic [RGB_W-1:0] color_r,
    input  logic [RGB_W-1:0] flash_color,
    input  logic             hit_l,
    input  logic             hit_r,
    output logic [10:0]      vcount_out,
    output logic [10:0]      hcount_out,
    output logic             vsync_out,
    output logic             hsync_out,
    output logic             vblnk_out,
    output logic             hblnk_out,
    output logic [RGB_W-1:0] rgb_out,
    output logic             flash_l,
    output logic             flash_r
);
    // state | meaning
    // IDLE  | paddle drawn in its normal colour
    // FLASH | paddle drawn in flash_color, cnt counts remaining vsync rises
    typedef enum logic {IDLE, FLASH} flash_state_t;

    localparam logic [11:0] Y_MAX  = 12'(V_ACTIVE - LENGTH);
    localparam logic [12:0] LEN13  = 13'(LENGTH);
    localparam logic [12:0] XL_LO  = 13'(XPOS_L - WIDTH);
    localparam logic [12:0] XL_HI  = 13'(XPOS_L);
    localparam logic [12:0] XR_LO  = 13'(XPOS_R);
    localparam logic [12:0] XR_HI  = 13'(XPOS_R + WIDTH);
    localparam logic [7:0]  FF_CNT = 8'(FLASH_FRAMES);

    logic [10:0]      vcount_d, hcount_d;
    logic             vsync_d, hsync_d, vblnk_d, hblnk_d;
    logic [RGB_W-1:0] rgb_d;
    logic             hit_l_d, hit_r_d;
    logic [11:0]      ylat_l, ylat_r;

    flash_state_t state [2];
    flash_state_t state_nxt [2];
    logic [7:0]   cnt [2];
    logic [7:0]   cnt_nxt [2];
    logic [1:0]   hit;

    logic [12:0] v13, h13;
    logic        in_l, in_r, vblnk_rise, vsync_rise;
    logic [RGB_W-1:0] col_l, col_r;

    assign v13 = {2'b00, vcount_in};
    assign h13 = {2'b00, hcount_in};
    assign in_l = (v13 >= {1'b0, ylat_l}) && (v13 < {1'b0, ylat_l} + LEN13) &&
                  (h13 >= XL_LO) && (h13 < XL_HI);
    assign in_r = (v13 >= {1'b0, ylat_r}) && (v13 < {1'b0, ylat_r} + LEN13) &&
                  (h13 >= XR_LO) && (h13 < XR_HI);

    // The stage-1 copies double as the previous-value registers for edge detection.
    assign vblnk_rise = vblnk_in & ~vblnk_d;
    assign vsync_rise = vsync_in & ~vsync_d;
    assign hit        = {hit_r, hit_l};

    assign flash_l = (state[0] == FLASH);
    assign flash_r = (state[1] == FLASH);
    assign col_l   = (state[0] == FLASH) ? flash_color : color_l;
    assign col_r   = (state[1] == FLASH) ? flash_color : color_r;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            case (state[i])
                IDLE: begin
                    if (hit[i] && FLASH_FRAMES > 0) begin
                        state_nxt[i] = FLASH;
                        cnt_nxt[i]   = FF_CNT;
                    end
                end
                FLASH: begin
                    if (hit[i]) begin
                        cnt_nxt[i] = FF_CNT;
                    end else if (vsync_rise) begin
                        if (cnt[i] == 8'd1) begin
                            state_nxt[i] = IDLE;
                            cnt_nxt[i]   = 8'd0;
                        end else begin
                            cnt_nxt[i] = cnt[i] - 8'd1;
                        end
                    end
                end
                default: begin
                    state_nxt[i] = IDLE;
                    cnt_nxt[i]   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            vcount_d   <= '0;
            hcount_d   <= '0;
            vsync_d    <= 1'b0;
            hsync_d    <= 1'b0;
            vblnk_d    <= 1'b0;
            hblnk_d    <= 1'b0;
            rgb_d      <= '0;
            hit_l_d    <= 1'b0;
            hit_r_d    <= 1'b0;
            ylat_l     <= '0;
            ylat_r     <= '0;
            vcount_out <= '0;
            hcount_out <= '0;
            vsync_out  <= 1'b0;
            hsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            rgb_out    <= '0;
            for (int i = 0; i < 2; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= 8'd0;
            end
        end else begin
            vcount_d <= vcount_in;
            hcount_d <= hcount_in;
            vsync_d  <= vsync_in;
            hsync_d  <= hsync_in;
            vblnk_d  <= vblnk_in;
            hblnk_d  <= hblnk_in;
            rgb_d    <= rgb_in;
            hit_l_d  <= in_l;
            hit_r_d  <= in_r;
            if (vblnk_rise) begin
                ylat_l <= (y_pos_l > Y_MAX) ? Y_MAX : y_pos_l;
                ylat_r <= (y_pos_r > Y_MAX) ? Y_MAX : y_pos_r;
            end
            vcount_out <= vcount_d;
            hcount_out <= hcount_d;
            vsync_out  <= vsync_d;
            hsync_out  <= hsync_d;
            vblnk_out  <= vblnk_d;
            hblnk_out  <= hblnk_d;
            if (hblnk_d || vblnk_d)
                rgb_out <= '0;
            else if (hit_l_d)
                rgb_out <= col_l;
            else if (hit_r_d)
                rgb_out <= col_r;
            else
                rgb_out <= rgb_d;
            for (int i = 0; i < 2; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
        end
    end
endmodule
